// File: rtl/mdu_sched.sv
// Purpose: multiply/divide sequencer; computes the result at issue, holds it, commits it to HI/LO.
// Latency: a mult/div started at cycle T is busy T+1..T+LAT, and the new HI/LO are visible at T+LAT+1.
// Backpressure: stall_md holds MDU ops in D during the start cycle and while busy; ops seen in EX while busy are dropped.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   op_valid_e      EX-stage instruction is a valid MDU op
//   op_e            1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   rs_e, rt_e      forwarded EX operands
//   md_use_d        D-stage instruction uses the MDU
//   start           combinational accept of a mult/div
//   busy            registered, high while an op is in flight
//   stall_md        combinational D-stage stall request
//   hi, lo          registered HI/LO
//   mf_data         combinational mfhi/mflo read data
module mdu_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid_e,
   input  logic [3:0]  op_e,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   input  logic        md_use_d,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_data
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       pend_hi_q, pend_hi_d;
   logic [31:0]       pend_lo_q, pend_lo_d;
   logic              pend_dz_q, pend_dz_d;

   // Arithmetic datapath, evaluated on the issue cycle only.
   logic [63:0] rs_sx, rt_sx, rs_zx, rt_zx;
   logic [63:0] prod_s, prod_u;
   logic [31:0] rs_mag, rt_mag, div_s_den, div_u_den;
   logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
   logic        div_by_zero;

   always_comb begin
      rs_sx  = {{32{rs_e[31]}}, rs_e};
      rt_sx  = {{32{rt_e[31]}}, rt_e};
      rs_zx  = {32'd0, rs_e};
      rt_zx  = {32'd0, rt_e};
      // Low 64 bits of the sign-extended product equal the signed 32x32 product.
      prod_s = rs_sx * rt_sx;
      prod_u = rs_zx * rt_zx;

      div_by_zero = (rt_e == 32'd0);
      rs_mag = rs_e[31] ? (~rs_e + 32'd1) : rs_e;
      rt_mag = rt_e[31] ? (~rt_e + 32'd1) : rt_e;
      // Substitute a divisor of 1 on divide-by-zero so the datapath never
      // produces undefined values; the result is discarded at commit anyway.
      div_s_den = div_by_zero ? 32'd1 : rt_mag;
      div_u_den = div_by_zero ? 32'd1 : rt_e;
      q_mag  = rs_mag / div_s_den;
      r_mag  = rs_mag % div_s_den;
      // Quotient truncates toward zero; remainder takes the dividend's sign.
      // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
      quo_s  = (rs_e[31] ^ rt_e[31]) ? (~q_mag + 32'd1) : q_mag;
      rem_s  = rs_e[31] ? (~r_mag + 32'd1) : r_mag;
      quo_u  = rs_e / div_u_den;
      rem_u  = rs_e % div_u_den;
   end

   assign start    = op_valid_e && (op_e >= 4'd1) && (op_e <= 4'd4) && (state_q == S_IDLE);
   assign busy     = busy_q;
   assign stall_md = md_use_d && (start || busy_q);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign mf_data  = (op_e == 4'd5) ? hi_q :
                     (op_e == 4'd6) ? lo_q : 32'd0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               case (op_e)
                  4'd1: begin
                     {pend_hi_d, pend_lo_d} = prod_s;
                     pend_dz_d = 1'b0;
                     cnt_d     = MULT_CNT;
                  end
                  4'd2: begin
                     {pend_hi_d, pend_lo_d} = prod_u;
                     pend_dz_d = 1'b0;
                     cnt_d     = MULT_CNT;
                  end
                  4'd3: begin
                     pend_hi_d = rem_s;
                     pend_lo_d = quo_s;
                     pend_dz_d = div_by_zero;
                     cnt_d     = DIV_CNT;
                  end
                  default: begin
                     pend_hi_d = rem_u;
                     pend_lo_d = quo_u;
                     pend_dz_d = div_by_zero;
                     cnt_d     = DIV_CNT;
                  end
               endcase
            end else if (op_valid_e && (op_e == 4'd7)) begin
               hi_d = rs_e;
            end else if (op_valid_e && (op_e == 4'd8)) begin
               lo_d = rs_e;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
               if (!pend_dz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_dz_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
      end
   end

endmodule

// File: tb/tb_mdu_sched.sv
// Purpose: directed bench for mdu_sched with hand-computed HI/LO and timing expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: md_use_d and in-flight op noise are exercised against stall_md/start.
module tb_mdu_sched;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk;
   logic        reset;
   logic        op_valid_e;
   logic [3:0]  op_e;
   logic [31:0] rs_e;
   logic [31:0] rt_e;
   logic        md_use_d;
   logic        start;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_data;

   int n_vec = 0;
   int n_err = 0;

   mdu_sched #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT),
      .CNT_W   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid_e(op_valid_e),
      .op_e      (op_e),
      .rs_e      (rs_e),
      .rt_e      (rt_e),
      .md_use_d  (md_use_d),
      .start     (start),
      .busy      (busy),
      .stall_md  (stall_md),
      .hi        (hi),
      .lo        (lo),
      .mf_data   (mf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Move to the next cycle's drive point (1ns after the rising edge).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
      op_valid_e = 1'b1;
      op_e       = op;
      rs_e       = val;
      next_cycle();
      op_valid_e = 1'b0;
      op_e       = 4'd0;
   endtask

   // Issue a mult/div in the current cycle, check start/busy/stall each cycle
   // and the committed HI/LO on the first idle cycle. With noise set, an
   // mthi is presented in EX throughout the busy period and must be ignored.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic md, input logic noise,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      op_valid_e = 1'b1;
      op_e       = op;
      rs_e       = a;
      rt_e       = b;
      md_use_d   = md;
      #1;
      check_eq({tag, ".start"}, 32'(start), 32'd1);
      check_eq({tag, ".busy0"}, 32'(busy), 32'd0);
      check_eq({tag, ".stall0"}, 32'(stall_md), 32'(md));
      for (int i = 1; i <= lat; i++) begin
         next_cycle();
         if (noise) begin
            op_valid_e = 1'b1;
            op_e       = 4'd7;
            rs_e       = 32'hDEADBEEF;
         end else begin
            op_valid_e = 1'b0;
            op_e       = 4'd0;
         end
         #1;
         check_eq($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
         check_eq($sformatf("%s.nostart%0d", tag, i), 32'(start), 32'd0);
         check_eq($sformatf("%s.stall%0d", tag, i), 32'(stall_md), 32'(md));
      end
      next_cycle();
      op_valid_e = 1'b0;
      op_e       = 4'd0;
      #1;
      check_eq({tag, ".done_busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".done_stall"}, 32'(stall_md), 32'd0);
      check_eq({tag, ".hi"}, hi, exp_hi);
      check_eq({tag, ".lo"}, lo, exp_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      op_valid_e = 1'b0;
      op_e       = 4'd0;
      rs_e       = 32'd0;
      rt_e       = 32'd0;
      md_use_d   = 1'b0;

      next_cycle();
      next_cycle();
      #1;
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.hi", hi, 32'd0);
      check_eq("rst.lo", lo, 32'd0);
      check_eq("rst.start", 32'(start), 32'd0);
      check_eq("rst.stall", 32'(stall_md), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      // mthi/mtlo and mfhi/mflo
      write_hilo(4'd7, 32'hA5A5_0001);
      write_hilo(4'd8, 32'h5A5A_0002);
      #1;
      check_eq("mthi.hi", hi, 32'hA5A5_0001);
      check_eq("mtlo.lo", lo, 32'h5A5A_0002);
      op_e = 4'd5;
      #1;
      check_eq("mfhi", mf_data, 32'hA5A5_0001);
      op_e = 4'd6;
      #1;
      check_eq("mflo", mf_data, 32'h5A5A_0002);
      op_e = 4'd9;
      #1;
      check_eq("mf_other", mf_data, 32'd0);
      op_e = 4'd0;
      next_cycle();

      // Operations run back to back: each starts on the previous one's first idle cycle.
      run_op("mult",   4'd1, 32'hFFFFFFFE, 32'd3,        MULT_LAT, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu",  4'd2, 32'hFFFFFFFE, 32'd3,        MULT_LAT, 1'b0, 1'b0, 32'h00000002, 32'hFFFFFFFA);
      run_op("div",    4'd3, 32'hFFFFFFF9, 32'd2,        DIV_LAT,  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_np", 4'd3, 32'd7,        32'hFFFFFFFE, DIV_LAT,  1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFD);
      run_op("div_ov", 4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_LAT,  1'b0, 1'b0, 32'h00000000, 32'h80000000);
      run_op("divu",   4'd4, 32'hFFFFFFFF, 32'h10,       DIV_LAT,  1'b0, 1'b0, 32'h0000000F, 32'h0FFFFFFF);
      run_op("multu2", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_LAT, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001);

      // Divide by zero leaves HI/LO untouched after the full busy period.
      write_hilo(4'd7, 32'h11);
      write_hilo(4'd8, 32'h22);
      run_op("divu0",  4'd4, 32'd7,        32'd0,        DIV_LAT,  1'b0, 1'b0, 32'h00000011, 32'h00000022);

      // D-stage stall across a mult, with an mthi in EX while busy that must be dropped.
      run_op("mult_md", 4'd1, 32'd6,       32'd7,        MULT_LAT, 1'b1, 1'b1, 32'h00000000, 32'h0000002A);
      md_use_d   = 1'b0;
      op_valid_e = 1'b1;
      op_e       = 4'd6;
      #1;
      check_eq("mflo_after", mf_data, 32'h0000002A);
      op_valid_e = 1'b0;
      op_e       = 4'd0;
      next_cycle();

      // Reset in the middle of a div: in-flight result is discarded.
      op_valid_e = 1'b1;
      op_e       = 4'd3;
      rs_e       = 32'd100;
      rt_e       = 32'd7;
      #1;
      check_eq("rdiv.start", 32'(start), 32'd1);
      next_cycle();
      op_valid_e = 1'b0;
      op_e       = 4'd0;
      next_cycle();
      next_cycle();
      #1;
      check_eq("rdiv.busy3", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_eq("rdiv.rst_busy", 32'(busy), 32'd0);
      check_eq("rdiv.rst_hi", hi, 32'd0);
      check_eq("rdiv.rst_lo", lo, 32'd0);
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < DIV_LAT; i++) begin
         next_cycle();
         #1;
         check_eq($sformatf("rdiv.idle_busy%0d", i), 32'(busy), 32'd0);
         check_eq($sformatf("rdiv.idle_lo%0d", i), lo, 32'd0);
      end
      run_op("mult_rst", 4'd1, 32'hFFFFFFF9, 32'd9, MULT_LAT, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFC1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
